// File: rtl/map_pkg.sv
// Shared map geometry, direction/state encodings and the default map image.
// Imported by the player controller, its ROM wiring and the VGA stage.
package map_pkg;

    localparam int MAP_W    = 21;
    localparam int MAP_H    = 30;
    localparam int TILE_PX  = 20;
    localparam int ADDRW    = $clog2(MAP_W);
    localparam int YIDX_W   = $clog2(MAP_H);
    localparam int POS_W    = 8;
    localparam int MAP_BITS = MAP_W * MAP_H;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        CHECK  = 2'd2
    } ctrl_state_t;

    // Map image with walls around the outer ring of tiles.
    // Word w (tile x) occupies bits [w*MAP_H +: MAP_H]; bit y inside it is tile y.
    function automatic logic [MAP_BITS-1:0] border_map();
        logic [MAP_BITS-1:0] m;
        m = '0;
        for (int w = 0; w < MAP_W; w++) begin
            for (int b = 0; b < MAP_H; b++) begin
                if ((w == 0) || (w == MAP_W - 1) || (b == 0) || (b == MAP_H - 1)) begin
                    m[w * MAP_H + b] = 1'b1;
                end
            end
        end
        return m;
    endfunction

    localparam logic [MAP_BITS-1:0] DEFAULT_MAP = border_map();

endpackage

// File: rtl/player_controller_if.sv
// Game-side signal bundle of the player controller: tick, buttons and the
// committed tile position with its status flags.
interface player_controller_if;
    import map_pkg::*;

    logic             tick;
    logic             btn_up;
    logic             btn_down;
    logic             btn_left;
    logic             btn_right;
    logic [POS_W-1:0] player_x_pos;
    logic [POS_W-1:0] player_y_pos;
    logic             busy;
    logic             blocked;

    // Stimulus / game-logic side
    modport master (
        output tick, btn_up, btn_down, btn_left, btn_right,
        input  player_x_pos, player_y_pos, busy, blocked
    );

    // Controller side
    modport slave (
        input  tick, btn_up, btn_down, btn_left, btn_right,
        output player_x_pos, player_y_pos, busy, blocked
    );

endinterface

// File: rtl/rom.sv
// Map ROM: DEPTH words of WIDTH bits, one-cycle registered read.
// Contents come from INIT_MAP, the packed image built from the INIT_F map
// source; an empty INIT_F yields a wall-free map.
module rom #(
    parameter int                         WIDTH    = 30,
    parameter int                         DEPTH    = 21,
    parameter string                      INIT_F   = "",
    parameter logic [WIDTH*DEPTH-1:0]     INIT_MAP = '0
) (
    input  logic                     clk,
    input  logic [$clog2(DEPTH)-1:0] addr,
    output logic [WIDTH-1:0]         data_out
);

    localparam bit                     HAS_INIT = (INIT_F != "");
    localparam logic [WIDTH*DEPTH-1:0] CONTENT  = HAS_INIT ? INIT_MAP : '0;

    logic [WIDTH-1:0] data_q;

    // Registered read; addresses beyond the last word read as open floor
    always_ff @(posedge clk) begin
        if (int'(addr) < DEPTH) begin
            data_q <= CONTENT[int'(addr) * WIDTH +: WIDTH];
        end else begin
            data_q <= '0;
        end
    end

    assign data_out = data_q;

endmodule

// File: rtl/player_controller.sv
// Player controller: samples the direction buttons on game ticks, checks the
// neighbouring tile against map bounds and the wall ROM, and commits the move.
module player_controller
    import map_pkg::*;
#(
    parameter int                    START_X  = 1,
    parameter int                    START_Y  = 1,
    parameter int                    MOVE_DIV = 8,
    parameter string                 INIT_F   = "map.mem",
    parameter logic [MAP_BITS-1:0]   INIT_MAP = DEFAULT_MAP
) (
    input  logic                clk,
    input  logic                reset,
    player_controller_if.slave  bus
);

    localparam int                     HOLD_W      = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam logic [HOLD_W-1:0]      HOLD_RELOAD = HOLD_W'(MOVE_DIV - 1);
    localparam logic signed [8:0]      MAX_X_S     = 9'(MAP_W - 1);
    localparam logic signed [8:0]      MAX_Y_S     = 9'(MAP_H - 1);

    // Direction decode and neighbour target
    dir_t              dir_s;
    logic              any_btn_s;
    logic signed [8:0] dx_s;
    logic signed [8:0] dy_s;
    logic signed [8:0] tx_d;
    logic signed [8:0] ty_d;
    logic              in_map_s;

    // ROM interface
    logic [ADDRW-1:0]  rom_addr_s;
    logic [MAP_H-1:0]  rom_data_s;
    logic              wall_s;

    // State
    ctrl_state_t       state_q;
    logic [POS_W-1:0]  x_q;
    logic [POS_W-1:0]  y_q;
    logic [ADDRW-1:0]  tx_q;
    logic [YIDX_W-1:0] ty_q;
    logic [HOLD_W-1:0] hold_q;
    logic              busy_q;
    logic              blocked_q;

    // Priority direction pick (up > down > left > right)
    always_comb begin
        dir_s = DIR_NONE;
        if (bus.btn_up) begin
            dir_s = DIR_UP;
        end else if (bus.btn_down) begin
            dir_s = DIR_DOWN;
        end else if (bus.btn_left) begin
            dir_s = DIR_LEFT;
        end else if (bus.btn_right) begin
            dir_s = DIR_RIGHT;
        end else begin
            dir_s = DIR_NONE;
        end
    end

    // Signed step and neighbour tile, with the map-bounds test
    always_comb begin
        dx_s = 9'sd0;
        dy_s = 9'sd0;
        case (dir_s)
            DIR_UP:    dy_s = -9'sd1;
            DIR_DOWN:  dy_s =  9'sd1;
            DIR_LEFT:  dx_s = -9'sd1;
            DIR_RIGHT: dx_s =  9'sd1;
            default: begin
                dx_s = 9'sd0;
                dy_s = 9'sd0;
            end
        endcase
        tx_d     = $signed({1'b0, x_q}) + dx_s;
        ty_d     = $signed({1'b0, y_q}) + dy_s;
        in_map_s = (tx_d >= 9'sd0) && (tx_d <= MAX_X_S) &&
                   (ty_d >= 9'sd0) && (ty_d <= MAX_Y_S);
    end

    assign any_btn_s  = (dir_s != DIR_NONE);
    assign rom_addr_s = tx_q;
    assign wall_s     = rom_data_s[ty_q];

    rom #(
        .WIDTH    (MAP_H),
        .DEPTH    (MAP_W),
        .INIT_F   (INIT_F),
        .INIT_MAP (INIT_MAP)
    ) u_rom (
        .clk      (clk),
        .addr     (rom_addr_s),
        .data_out (rom_data_s)
    );

    // Move FSM: start/repeat gating in IDLE, ROM wait in LOOKUP, wall check and commit in CHECK
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            x_q       <= POS_W'(START_X);
            y_q       <= POS_W'(START_Y);
            tx_q      <= '0;
            ty_q      <= '0;
            hold_q    <= '0;
            busy_q    <= 1'b0;
            blocked_q <= 1'b0;
        end else begin
            blocked_q <= 1'b0;
            // Releasing every button re-arms an immediate move on the next press
            if (!any_btn_s) begin
                hold_q <= '0;
            end
            case (state_q)
                IDLE: begin
                    busy_q <= 1'b0;
                    if (any_btn_s && bus.tick) begin
                        if (hold_q == '0) begin
                            hold_q <= HOLD_RELOAD;
                            if (in_map_s) begin
                                tx_q    <= tx_d[ADDRW-1:0];
                                ty_q    <= ty_d[YIDX_W-1:0];
                                busy_q  <= 1'b1;
                                state_q <= LOOKUP;
                            end else begin
                                blocked_q <= 1'b1;
                            end
                        end else begin
                            hold_q <= hold_q - HOLD_W'(1);
                        end
                    end
                end
                LOOKUP: begin
                    busy_q  <= 1'b1;
                    state_q <= CHECK;
                end
                CHECK: begin
                    if (wall_s) begin
                        blocked_q <= 1'b1;
                    end else begin
                        x_q <= POS_W'(tx_q);
                        y_q <= POS_W'(ty_q);
                    end
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.player_x_pos = x_q;
    assign bus.player_y_pos = y_q;
    assign bus.busy         = busy_q;
    assign bus.blocked      = blocked_q;

endmodule

// File: tb/tb_player_controller.sv
// Scoreboard bench for player_controller: directed scenarios followed by
// random buttons/ticks/resets, checked against a tile-level reference model.
module tb_player_controller;
    import map_pkg::*;

    localparam int START_X  = 1;
    localparam int START_Y  = 1;
    localparam int MOVE_DIV = 2;
    localparam logic [MAP_BITS-1:0] TB_MAP = MAP_BITS'(1) << (2 * MAP_H + 1);

    localparam bit [3:0] B_U = 4'b1000;
    localparam bit [3:0] B_D = 4'b0100;
    localparam bit [3:0] B_L = 4'b0010;
    localparam bit [3:0] B_R = 4'b0001;

    typedef struct {
        bit blk;
        int x;
        int y;
        int at;
    } exp_t;

    bit   clk;
    logic reset;

    player_controller_if pc_if();

    player_controller #(
        .START_X  (START_X),
        .START_Y  (START_Y),
        .MOVE_DIV (MOVE_DIV),
        .INIT_F   ("test_map.mem"),
        .INIT_MAP (TB_MAP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (pc_if.slave)
    );

    always #5 clk = ~clk;

    int   compared   = 0;
    int   mismatched = 0;
    int   edge_no    = 0;
    bit   mon_en     = 1'b0;
    bit   rst_edge   = 1'b0;
    exp_t expq[$];

    // Reference model state
    int   mx, my, hold, busy_start;
    int   px, py;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: actual=%0d required=%0d (edge %0d)", name, act, req, edge_no);
        end
    endtask

    function automatic bit is_wall(input int x, input int y);
        return (x == 2) && (y == 1);
    endfunction

    // Reference behaviour at one rising edge
    task automatic model_step(input bit tk, input bit [3:0] b, input bit rst);
        int dx, dy, tx, ty;
        exp_t e;
        if (rst) begin
            mx = START_X; my = START_Y; hold = 0; busy_start = -100;
            expq.delete();
            rst_edge = 1'b1;
            return;
        end
        rst_edge = 1'b0;
        if (b == 4'b0000) begin
            hold = 0;
            return;
        end
        if (!tk) return;
        if (edge_no <= busy_start + 2) return;
        if (hold != 0) begin
            hold = hold - 1;
            return;
        end
        hold = MOVE_DIV - 1;
        dx = 0; dy = 0;
        if (b[3])      dy = -1;
        else if (b[2]) dy = 1;
        else if (b[1]) dx = -1;
        else           dx = 1;
        tx = mx + dx;
        ty = my + dy;
        if (tx < 0 || tx > MAP_W - 1 || ty < 0 || ty > MAP_H - 1) begin
            e = '{blk: 1'b1, x: mx, y: my, at: edge_no};
        end else begin
            busy_start = edge_no;
            if (is_wall(tx, ty)) begin
                e = '{blk: 1'b1, x: mx, y: my, at: edge_no + 2};
            end else begin
                mx = tx; my = ty;
                e = '{blk: 1'b0, x: tx, y: ty, at: edge_no + 2};
            end
        end
        expq.push_back(e);
    endtask

    task automatic cycle(input bit tk, input bit [3:0] b, input bit rst);
        reset           = rst;
        pc_if.tick      = tk;
        pc_if.btn_up    = b[3];
        pc_if.btn_down  = b[2];
        pc_if.btn_left  = b[1];
        pc_if.btn_right = b[0];
        @(posedge clk);
        edge_no++;
        model_step(tk, b, rst);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 4'b0000, 1'b0);
    endtask

    task automatic press(input bit [3:0] b);
        cycle(1'b1, b, 1'b0);
        idle(4);
    endtask

    // Monitor: busy every cycle; on each blocked pulse or position change pop and compare
    always @(negedge clk) begin
        if (mon_en) begin
            chk("busy", {31'd0, pc_if.busy}, ((edge_no >= busy_start) && (edge_no < busy_start + 2)) ? 32'd1 : 32'd0);
            if (rst_edge) begin
                chk("reset_x", pc_if.player_x_pos, START_X);
                chk("reset_y", pc_if.player_y_pos, START_Y);
                chk("reset_blocked", {31'd0, pc_if.blocked}, 32'd0);
                px = int'(pc_if.player_x_pos);
                py = int'(pc_if.player_y_pos);
            end else if (pc_if.blocked !== 1'b0 || int'(pc_if.player_x_pos) != px ||
                         int'(pc_if.player_y_pos) != py) begin
                if (expq.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_event: actual blocked=%0b pos=(%0d,%0d) required no event (edge %0d)",
                             pc_if.blocked, pc_if.player_x_pos, pc_if.player_y_pos, edge_no);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("kind_blocked", {31'd0, pc_if.blocked}, {31'd0, e.blk});
                    chk("pos_x", pc_if.player_x_pos, e.x);
                    chk("pos_y", pc_if.player_y_pos, e.y);
                    chk("event_edge", edge_no, e.at);
                end
                px = int'(pc_if.player_x_pos);
                py = int'(pc_if.player_y_pos);
            end
        end
    end

    initial begin
        mx = START_X; my = START_Y; hold = 0; busy_start = -100;
        px = START_X; py = START_Y;
        mon_en = 1'b1;
        cycle(1'b0, 4'b0000, 1'b1);
        cycle(1'b0, 4'b0000, 1'b1);
        idle(2);

        // 1: reset while the right-move is in LOOKUP
        cycle(1'b1, B_R, 1'b0);
        cycle(1'b0, B_R, 1'b1);
        idle(3);

        // 2: plain down move
        press(B_D);
        chk("t2_x", pc_if.player_x_pos, 1);
        chk("t2_y", pc_if.player_y_pos, 2);

        // 3: back up, then right into the wall at (2,1)
        press(B_U);
        press(B_R);
        chk("t3_x", pc_if.player_x_pos, 1);
        chk("t3_y", pc_if.player_y_pos, 1);

        // 4: walk to (0,5) and try to leave the map on the left
        for (int i = 0; i < 4; i++) press(B_D);
        press(B_L);
        press(B_L);
        chk("t4_x", pc_if.player_x_pos, 0);
        chk("t4_y", pc_if.player_y_pos, 5);
        press(B_R);

        // 5: up held over five ticks ten cycles apart
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, B_U, 1'b0);
            for (int j = 0; j < 9; j++) cycle(1'b0, B_U, 1'b0);
        end
        idle(4);
        chk("t5_x", pc_if.player_x_pos, 1);
        chk("t5_y", pc_if.player_y_pos, 2);

        // 6: up+right with an extra tick while busy
        for (int i = 0; i < 3; i++) press(B_D);
        cycle(1'b1, B_U | B_R, 1'b0);
        cycle(1'b1, B_U | B_R, 1'b0);
        idle(4);
        chk("t6_x", pc_if.player_x_pos, 1);
        chk("t6_y", pc_if.player_y_pos, 4);

        // Random buttons, ticks and occasional resets
        for (int i = 0; i < 600; i++) begin
            bit       tk;
            bit [3:0] b;
            bit       rs;
            tk = ($urandom_range(0, 2) == 0);
            for (int k = 0; k < 4; k++) b[k] = ($urandom_range(0, 3) == 0);
            rs = ($urandom_range(0, 149) == 0);
            cycle(tk, b, rs);
        end
        idle(6);
        chk("leftover_expected", expq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/player_controller.md
Name: player_controller

Overview:
- Upstream stage of the VGA controller; produces the player_x_pos/player_y_pos tile coordinates that the VGA stage renders.
- Samples four direction buttons once per game tick and computes the neighbouring target tile.
- Rejects any move that leaves the map or lands on a wall bit in the map ROM; otherwise commits the new position.
- Runs on the system clock and reads its own instance of the shared map ROM (21 words x 30 bits).

Parameters:
- START_X, 1, reset tile x (ROM word index), 0..20
- START_Y, 1, reset tile y (bit index within word), 0..29
- MOVE_DIV, 8, number of ticks between repeated moves while a button stays held; must be >= 1
- INIT_F, "map.mem", map ROM init file

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- tick  input  1  single-cycle game-tick strobe, already synchronous to clk
- btn_up  input  1  level, already synchronized and debounced; y-1
- btn_down  input  1  level; y+1
- btn_left  input  1  level; x-1
- btn_right  input  1  level; x+1
- player_x_pos  output  8  committed tile x, 0..20
- player_y_pos  output  8  committed tile y, 0..29
- busy  output  1  high while a move is in flight
- blocked  output  1  one-cycle pulse when a move is rejected

Behaviour:
- Reset values: player_x_pos=START_X, player_y_pos=START_Y, busy=0, blocked=0, hold_cnt=0, FSM=IDLE.
- Reset asserted in any state aborts the in-flight move with no commit.
- Direction priority when several buttons are high: up > down > left > right. Exactly one direction is acted on per move.
- Repeat counter (hold_cnt):
  - Any button high and tick in IDLE: a move is started only if hold_cnt==0; hold_cnt then loads MOVE_DIV-1.
  - Any button high and tick in IDLE with hold_cnt != 0: hold_cnt decrements and no move starts.
  - All buttons low: hold_cnt is forced to 0, so a fresh press moves on the very next tick.
- FSM states: IDLE, LOOKUP, CHECK.
- IDLE, on a move start at edge n:
  - Compute the target (tx,ty) with 9-bit signed arithmetic.
  - If tx<0, tx>20, ty<0 or ty>29: stay IDLE, blocked=1 for the following cycle, position unchanged. The edge case is x=0 with left.
  - Otherwise: register the target, drive rom addr=tx, go to LOOKUP.
- LOOKUP (edge n+1): the ROM registers data_out (1-cycle read latency); go to CHECK.
- CHECK (edge n+2):
  - If data_out[ty]==1 (wall): blocked pulses for one cycle and the position is unchanged.
  - Otherwise: player_x_pos<=tx and player_y_pos<=ty.
  - Return to IDLE.
- Latency: the new position is visible after edge n+2.
- busy=1 in LOOKUP and CHECK; busy=0 in IDLE.
- A tick arriving while busy is ignored: it is neither queued nor counted in hold_cnt.
- Buttons are sampled only at the move-start edge; later changes do not alter an in-flight move.
- Outputs are zero-extended: upper bits of player_x_pos and player_y_pos are always 0.
- There is no wrap-around at map edges.

Decomposition:
- Shared package map_pkg holds:
  - MAP_W=21, MAP_H=30, TILE_PX=20
  - ADDRW=$clog2(MAP_W)
  - dir_t enum {DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT}
  - ctrl_state_t enum {IDLE, LOOKUP, CHECK}
- The VGA stage imports the same package constants.
- One sub-module: the existing rom (WIDTH=MAP_H, DEPTH=MAP_W, INIT_F), instantiated unchanged.
- Priority direction encoding stays inline; no further sub-module.

Test Plan:
Bench uses test_map.mem with wall bit set only at word 2 bit 1, START_X=1, START_Y=1, MOVE_DIV=2.
1. Reset mid-LOOKUP with btn_right held -> after reset: pos=(1,1), busy=0, blocked=0, no commit.
2. btn_down, one tick -> busy high for 2 cycles; pos=(1,2) after edge n+2; blocked stays 0.
3. From (1,1), btn_right, tick -> wall at (2,1): blocked pulses exactly 1 cycle at n+3, pos stays (1,1).
4. From (0,5), btn_left, tick -> bounds reject: blocked pulses at n+1, busy never rises, pos=(0,5).
5. btn_up held, 5 ticks spaced 10 cycles apart from (1,5) -> moves on ticks 1, 3 and 5 only; final pos=(1,2).
6. btn_up+btn_right together, plus a second tick during busy -> up wins, one move only: (1,5)->(1,4); the second tick is dropped.
